fetch: RTL

//  Instruction fetch stage. Owns the PC, issues reads to a 1-cycle-latency

---
 rtl/fetch.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// hands {pc, inst} to decode through a 2-entry skid FIFO with redirect flush.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  logic            run;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [XLEN-1:0] buf_inst [DEPTH];
  logic            head;
  logic [1:0]      count;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic            pop;
  logic            push;
  logic            issue;
  logic            tail;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] raddr;

  // Issue whenever the words already owed to decode leave a free FIFO slot.
  always_comb begin
    o_valid      = (count != 2'd0) & ~i_redirect;
    pop          = o_valid & i_ready;
    occupancy    = 3'(count) + 3'(inflight) - 3'(pop);
    issue        = run & ((occupancy < 3'd2) | i_redirect);
    raddr        = i_redirect ? {i_redirect_pc[XLEN-1:2], 2'b00} : pc;
    push         = inflight & ~i_redirect;
    tail         = head ^ count[0];
    o_imem_ren   = issue;
    o_imem_raddr = raddr;
    o_pc         = buf_pc[head];
    o_inst       = o_valid ? buf_inst[head] : NOP;
  end

  // run holds off the first request until the cycle after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run         <= 1'b0;
      pc          <= RESET_ADDR;
      head        <= 1'b0;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= RESET_ADDR;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]   <= RESET_ADDR;
        buf_inst[i] <= NOP;
      end
    end else begin
      run      <= 1'b1;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= raddr;
        pc          <= raddr + 32'd4;
      end
      if (i_redirect) begin
        count <= 2'd0;
      end else begin
        if (push) begin
          buf_pc[tail]   <= inflight_pc;
          buf_inst[tail] <= i_imem_rdata;
        end
        if (pop) head <= ~head;
        count <= count + 2'(push) - 2'(pop);
      end
    end
  end

endmodule
